// File: rtl/div_unit_sequencer_if.sv
// Operation-type package and the issue-side interface of the iterative divider.
package div_unit_sequencer_pkg;
  typedef enum logic [1:0] {
    DIV  = 2'b00,
    DIVU = 2'b01,
    REM  = 2'b10,
    REMU = 2'b11
  } div_operation_t;
endpackage

interface div_unit_sequencer_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                                   clear_i;
  logic                                   data_valid_i;
  logic [DATA_WIDTH-1:0]                  dividend_i;
  logic [DATA_WIDTH-1:0]                  divisor_i;
  div_unit_sequencer_pkg::div_operation_t operation_i;
  logic [DATA_WIDTH-1:0]                  result_o;
  logic                                   data_valid_o;
  logic                                   divide_by_zero_o;
  logic                                   idle_o;

  modport master (
    output clear_i, data_valid_i, dividend_i, divisor_i, operation_i,
    input  result_o, data_valid_o, divide_by_zero_o, idle_o
  );

  modport slave (
    input  clear_i, data_valid_i, dividend_i, divisor_i, operation_i,
    output result_o, data_valid_o, divide_by_zero_o, idle_o
  );
endinterface

// File: rtl/div_unit_sequencer.sv
// Radix-2 restoring divider for DIV/DIVU/REM/REMU with a fast path for
// divide-by-zero and signed overflow, and sign fix-up after iteration.
module div_unit_sequencer
  import div_unit_sequencer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = $clog2(DATA_WIDTH)
) (
  input logic                clk_i,
  input logic                rst_n_i,
  div_unit_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    PREPARE,
    DIVIDE,
    RESTORE,
    DONE
  } state_t;

  state_t                state, state_next;
  logic [CNT_WIDTH-1:0]  cnt;
  logic [DATA_WIDTH-1:0] quo;
  logic [DATA_WIDTH-1:0] dsr;
  logic [DATA_WIDTH-1:0] rem;
  div_operation_t        op_q;
  logic                  quo_neg;
  logic                  rem_neg;
  logic                  dbz_q;
  logic [DATA_WIDTH-1:0] result_q;

  logic                  signed_in;
  logic                  div_zero;
  logic                  overflow;
  logic                  fast;
  logic [DATA_WIDTH-1:0] fast_result;
  logic                  signed_q;
  logic [DATA_WIDTH:0]   shifted;
  logic [DATA_WIDTH:0]   diff;
  logic                  last_iter;

  assign signed_in = ~bus.operation_i[0];
  assign div_zero  = (bus.divisor_i == '0);
  assign overflow  = signed_in && (bus.dividend_i == {1'b1, {(DATA_WIDTH-1){1'b0}}})
                     && (bus.divisor_i == '1);
  assign fast      = div_zero || overflow;
  assign signed_q  = ~op_q[0];
  assign last_iter = (cnt == CNT_WIDTH'(DATA_WIDTH - 1));

  // Bit 1 of the operation selects remainder; overflow gives dividend / zero.
  always_comb begin
    fast_result = '0;
    if (div_zero) begin
      fast_result = bus.operation_i[1] ? bus.dividend_i : '1;
    end else begin
      fast_result = bus.operation_i[1] ? '0 : bus.dividend_i;
    end
  end

  // The dividend register shifts out its MSB into the partial remainder while
  // quotient bits shift in at the bottom.
  assign shifted = {rem, quo[DATA_WIDTH-1]};
  assign diff    = shifted - {1'b0, dsr};

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (bus.clear_i) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (bus.data_valid_i) state_next = fast ? DONE : PREPARE;
        PREPARE: state_next = DIVIDE;
        DIVIDE:  if (last_iter) state_next = RESTORE;
        RESTORE: state_next = DONE;
        DONE:    state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt      <= '0;
      quo      <= '0;
      dsr      <= '0;
      rem      <= '0;
      op_q     <= DIV;
      quo_neg  <= 1'b0;
      rem_neg  <= 1'b0;
      dbz_q    <= 1'b0;
      result_q <= '0;
    end else if (bus.clear_i) begin
      cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.data_valid_i) begin
            quo   <= bus.dividend_i;
            dsr   <= bus.divisor_i;
            op_q  <= bus.operation_i;
            dbz_q <= div_zero;
            if (fast) result_q <= fast_result;
          end
        end
        PREPARE: begin
          if (signed_q && quo[DATA_WIDTH-1]) quo <= -quo;
          if (signed_q && dsr[DATA_WIDTH-1]) dsr <= -dsr;
          quo_neg <= signed_q && (quo[DATA_WIDTH-1] ^ dsr[DATA_WIDTH-1]);
          rem_neg <= signed_q && quo[DATA_WIDTH-1];
          rem     <= '0;
          cnt     <= '0;
        end
        DIVIDE: begin
          if (!diff[DATA_WIDTH]) begin
            rem <= diff[DATA_WIDTH-1:0];
            quo <= {quo[DATA_WIDTH-2:0], 1'b1};
          end else begin
            rem <= shifted[DATA_WIDTH-1:0];
            quo <= {quo[DATA_WIDTH-2:0], 1'b0};
          end
          cnt <= cnt + CNT_WIDTH'(1);
        end
        RESTORE: begin
          if (op_q[1]) begin
            result_q <= rem_neg ? -rem : rem;
          end else begin
            result_q <= quo_neg ? -quo : quo;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.result_o         = result_q;
  assign bus.data_valid_o     = (state == DONE);
  assign bus.divide_by_zero_o = (state == DONE) && dbz_q;
  assign bus.idle_o           = (state == IDLE);

endmodule
